// File: rtl/tile_match_engine.sv
// Pair-matching controller on the game side of the 16-entry tile RAM.
// Reads two tiles, clears them on a colour match, or holds a reveal window on a mismatch.
module tile_match_engine #(
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned NUM_PAIRS    = 8,
    parameter logic [7:0]  CLEARED_CODE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] sel0,
    input  logic [3:0] sel1,
    output logic [3:0] addrA,
    output logic [7:0] writeA,
    output logic       weA,
    input  logic [7:0] readA,
    output logic [3:0] addrB,
    output logic [7:0] writeB,
    output logic       weB,
    input  logic [7:0] readB,
    output logic       result_valid,
    output logic       result_match,
    output logic       result_reject,
    output logic       reveal_active,
    output logic [3:0] match_count,
    output logic       game_done
);

    localparam int unsigned HoldW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [3:0]  PairsMax = 4'(NUM_PAIRS);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCmp,
        StClear,
        StHold,
        StResult
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         sel0_q, sel0_d;
    logic [3:0]         sel1_q, sel1_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic               match_q, match_d;
    logic               reject_q, reject_d;
    logic [3:0]         count_q, count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            sel0_q   <= '0;
            sel1_q   <= '0;
            hold_q   <= '0;
            match_q  <= 1'b0;
            reject_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel0_q   <= sel0_d;
            sel1_q   <= sel1_d;
            hold_q   <= hold_d;
            match_q  <= match_d;
            reject_q <= reject_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel0_d    = sel0_q;
        sel1_d    = sel1_q;
        hold_d    = hold_q;
        match_d   = match_q;
        reject_d  = reject_q;
        count_d   = count_q;
        game_done = (count_q == PairsMax);
        req_ready = (state_q == StIdle) && !game_done;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    sel0_d  = sel0;
                    sel1_d  = sel1;
                    state_d = StRead;
                end
            end
            StRead: state_d = StCmp;
            StCmp: begin
                // Reject takes priority: same tile twice or either tile already empty.
                if ((sel0_q == sel1_q) || (readA == CLEARED_CODE) || (readB == CLEARED_CODE)) begin
                    match_d  = 1'b0;
                    reject_d = 1'b1;
                    state_d  = StResult;
                end else if (readA[7:1] == readB[7:1]) begin
                    state_d = StClear;
                end else begin
                    hold_d  = HoldW'(HOLD_CYCLES - 1);
                    state_d = StHold;
                end
            end
            StClear: begin
                if (count_q < PairsMax) begin
                    count_d = count_q + 4'd1;
                end
                match_d  = 1'b1;
                reject_d = 1'b0;
                state_d  = StResult;
            end
            StHold: begin
                if (hold_q == '0) begin
                    match_d  = 1'b0;
                    reject_d = 1'b0;
                    state_d  = StResult;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            StResult: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        addrA         = sel0_q;
        addrB         = sel1_q;
        writeA        = CLEARED_CODE;
        writeB        = CLEARED_CODE;
        weA           = (state_q == StClear);
        weB           = (state_q == StClear);
        result_valid  = (state_q == StResult);
        result_match  = match_q;
        result_reject = reject_q;
        reveal_active = (state_q == StHold);
        match_count   = count_q;
    end

endmodule

// File: tb/tb_tile_match_engine.sv
// Scoreboard bench for tile_match_engine with a registered-read tile RAM model.
module tb_tile_match_engine;

    localparam int unsigned HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] sel0, sel1;
    logic [3:0] addrA, addrB;
    logic [7:0] writeA, writeB;
    logic       weA, weB;
    logic [7:0] readA, readB;
    logic       result_valid, result_match, result_reject, reveal_active;
    logic [3:0] match_count;
    logic       game_done;

    tile_match_engine #(
        .HOLD_CYCLES (HOLD),
        .NUM_PAIRS   (8),
        .CLEARED_CODE(8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .sel0         (sel0),
        .sel1         (sel1),
        .addrA        (addrA),
        .writeA       (writeA),
        .weA          (weA),
        .readA        (readA),
        .addrB        (addrB),
        .writeB       (writeB),
        .weB          (weB),
        .readB        (readB),
        .result_valid (result_valid),
        .result_match (result_match),
        .result_reject(result_reject),
        .reveal_active(reveal_active),
        .match_count  (match_count),
        .game_done    (game_done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    logic [7:0] ram_init [16];
    logic       ram_load;

    always @(posedge clk) begin
        if (ram_load) begin
            mem <= ram_init;
        end else begin
            if (weA) mem[addrA] <= writeA;
            if (weB) mem[addrB] <= writeB;
        end
        readA <= mem[addrA];
        readB <= mem[addrB];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int reveal_cnt = 0;
    int results_seen = 0;

    typedef struct {
        logic m;
        logic r;
        int   lat;
        int   t0;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scores every result pulse and tallies write/reveal cycles.
    always @(negedge clk) begin
        if (weA) begin
            we_cnt++;
            chk("we_pair", {weB, writeA, writeB}, {1'b1, 8'h00, 8'h00});
        end
        if (reveal_active) reveal_cnt++;
        if (result_valid) begin
            results_seen++;
            if (q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result_match", result_match, e.m);
                chk("result_reject", result_reject, e.r);
                chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic issue(input logic [3:0] s0, input logic [3:0] s1,
                         input logic m, input logic r, input int lat);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd1, 32'd0);
            return;
        end
        req_valid = 1'b1;
        sel0 = s0;
        sel1 = s1;
        e.m = m; e.r = r; e.lat = lat; e.t0 = cyc;
        q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("result_timeout", q.size(), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ram_load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ram_load = 1'b0;
    endtask

    initial begin
        int n;
        logic saw_ready;
        ram_init = '{8'h3F, 8'hCB, 8'hE3, 8'hCA, 8'hE2, 8'h10, 8'h11, 8'h20,
                     8'h21, 8'h30, 8'h31, 8'h40, 8'h41, 8'h50, 8'h3E, 8'h51};
        reset = 1'b1;
        ram_load = 1'b1;
        req_valid = 1'b0;
        sel0 = '0;
        sel1 = '0;
        do_reset();

        chk("rst_addr", {addrA, addrB}, 8'h00);
        chk("rst_we", {weA, weB}, 2'b00);
        chk("rst_wdata", {writeA, writeB}, 16'h0000);
        chk("rst_flags", {result_valid, result_match, result_reject, reveal_active}, 4'b0000);
        chk("rst_count", {match_count, game_done}, 5'd0);
        chk("rst_ready", req_ready, 1'b1);

        // Match: 3F vs 3E differ only in bit 0.
        we_cnt = 0;
        issue(4'd0, 4'd14, 1'b1, 1'b0, 4);
        wait_done();
        chk("match_we_cycles", we_cnt, 1);
        chk("match_ram0", mem[0], 8'h00);
        chk("match_ram14", mem[14], 8'h00);
        chk("match_count1", match_count, 4'd1);

        // Mismatch: CB vs E3.
        we_cnt = 0; reveal_cnt = 0;
        issue(4'd1, 4'd2, 1'b0, 1'b0, 3 + HOLD);
        wait_done();
        chk("mis_reveal_cycles", reveal_cnt, HOLD);
        chk("mis_we_cycles", we_cnt, 0);
        chk("mis_ram", {mem[1], mem[2]}, 16'hCBE3);
        chk("mis_count", match_count, 4'd1);

        // Same address and empty tile both reject.
        we_cnt = 0;
        issue(4'd5, 4'd5, 1'b0, 1'b1, 3);
        wait_done();
        issue(4'd0, 4'd3, 1'b0, 1'b1, 3);
        wait_done();
        chk("rej_we_cycles", we_cnt, 0);
        chk("rej_ram3", mem[3], 8'hCA);

        // Clear the remaining seven pairs.
        issue(4'd1, 4'd3, 1'b1, 1'b0, 4);
        issue(4'd2, 4'd4, 1'b1, 1'b0, 4);
        issue(4'd5, 4'd6, 1'b1, 1'b0, 4);
        issue(4'd7, 4'd8, 1'b1, 1'b0, 4);
        issue(4'd9, 4'd10, 1'b1, 1'b0, 4);
        issue(4'd11, 4'd12, 1'b1, 1'b0, 4);
        issue(4'd13, 4'd15, 1'b1, 1'b0, 4);
        wait_done();
        chk("final_count", match_count, 4'd8);
        chk("game_done", game_done, 1'b1);
        chk("done_ready", req_ready, 1'b0);

        // Further requests after game over must get no response.
        n = results_seen;
        saw_ready = 1'b0;
        req_valid = 1'b1;
        sel0 = 4'd5;
        sel1 = 4'd6;
        repeat (20) begin
            @(negedge clk);
            if (req_ready) saw_ready = 1'b1;
        end
        req_valid = 1'b0;
        chk("done_no_ready", saw_ready, 1'b0);
        chk("done_no_result", results_seen - n, 0);
        chk("done_sticky", {game_done, match_count}, {1'b1, 4'd8});

        // Reset during HOLD aborts without a result.
        do_reset();
        chk("rst2_count", match_count, 4'd0);
        issue(4'd1, 4'd2, 1'b0, 1'b0, 3 + HOLD);
        n = 0;
        while (!reveal_active && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached", reveal_active, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        n = results_seen;
        @(posedge clk);
        #1;
        chk("abort_reveal", reveal_active, 1'b0);
        chk("abort_valid", result_valid, 1'b0);
        chk("abort_count", match_count, 4'd0);
        chk("abort_ready", req_ready, 1'b1);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_result", results_seen - n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tile_match_engine.md
Name: tile_match_engine

Overview:
- Controller on the game side of the 16-entry tile RAM. It drives RAM ports A and B and acts as the reader/writer for tile memory.
- It accepts a pair of selected tile addresses and reads both tiles.
- It compares their colours. On a match it clears both tiles to CLEARED_CODE and increments the pair score; on a mismatch it holds a reveal window before reporting.
- It sits between the player-input/cursor logic (request side) and the tile RAM and display (RAM side). It produces a one-cycle result pulse per request.

Parameters:
- HOLD_CYCLES, 4, number of cycles spent in HOLD after a mismatch (≥1).
- NUM_PAIRS, 8, number of matched pairs that ends the game.
- CLEARED_CODE, 8'h00, value written to a matched tile; a tile holding this value is treated as empty.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request carries a valid pair in sel0/sel1
- req_ready  out  1  engine can accept a request
- sel0  in  4  first tile address
- sel1  in  4  second tile address
- addrA  out  4  RAM port A address (= latched sel0)
- writeA  out  8  RAM port A write data
- weA  out  1  RAM port A write enable
- readA  in  8  RAM port A read data (registered, 1-cycle latency)
- addrB  out  4  RAM port B address (= latched sel1)
- writeB  out  8  RAM port B write data
- weB  out  1  RAM port B write enable
- readB  in  8  RAM port B read data (registered, 1-cycle latency)
- result_valid  out  1  one-cycle pulse, result fields valid
- result_match  out  1  pair matched and cleared
- result_reject  out  1  request rejected (same address or empty tile)
- reveal_active  out  1  high throughout HOLD
- match_count  out  4  matched pairs so far
- game_done  out  1  match_count == NUM_PAIRS

Behaviour:
- States: IDLE, READ, CMP, CLEAR, HOLD, RESULT.
- Reset values:
  - state = IDLE.
  - Latched addresses = 0, so addrA = addrB = 0.
  - weA = weB = 0; writeA = writeB = CLEARED_CODE.
  - result_valid, result_match, result_reject, reveal_active = 0.
  - match_count = 0, game_done = 0.
  - The hold counter is cleared.
  - Reset mid-operation aborts immediately; any pending write is dropped and no result pulse is produced.
- req_ready = (state == IDLE) && !game_done. A handshake is req_valid && req_ready at a rising edge. sel0 and sel1 are latched on that edge, then state goes to READ.
- Requests arriving while req_ready = 0 are ignored; the requester must hold them.
- addrA and addrB come from the latched registers and are stable from READ through RESULT.
- READ: the RAM samples the address. Next state is CMP.
- CMP: readA and readB are valid. Checks are evaluated in this order:
  - reject if sel0 == sel1, readA == CLEARED_CODE, or readB == CLEARED_CODE; go to RESULT with result_reject = 1;
  - else match if readA[7:1] == readB[7:1] (bit 0 is ignored); go to CLEAR;
  - else mismatch; load the hold counter with HOLD_CYCLES-1 and go to HOLD.
- CLEAR: for exactly one cycle, weA = weB = 1 and writeA = writeB = CLEARED_CODE. match_count increments (saturating at NUM_PAIRS). Next state is RESULT with result_match = 1.
- HOLD: reveal_active = 1. The counter decrements each cycle. When it reaches 0, go to RESULT with result_match = 0 and result_reject = 0.
- RESULT: result_valid = 1 for exactly one cycle, then IDLE.
  - result_match and result_reject hold their value until the next RESULT.
  - They are never both 1.
- game_done is set on the cycle match_count reaches NUM_PAIRS and stays set until reset.
- Latency, counted in cycles after the accept edge, with the result_valid cycle being:
  - reject: 3rd;
  - match: 4th;
  - mismatch: (3 + HOLD_CYCLES)th.
- weA and weB are never asserted outside CLEAR. The write and the read of the same address never overlap.

Test Plan:
- Reset, then req sel0=0, sel1=14 (8'h3F/8'h3E) → result_valid in 4th cycle after accept, result_match=1; weA=weB=1 for one cycle with write data 8'h00; RAM[0]=RAM[14]=8'h00; match_count=1.
- sel0=1, sel1=2 (8'hCB vs 8'hE3), HOLD_CYCLES=4 → reveal_active high 4 cycles; result_valid in 7th cycle; result_match=0, result_reject=0; RAM unchanged.
- sel0=5, sel1=5 → result_reject=1 in 3rd cycle; no write enable.
- After the first test, sel0=0, sel1=3 → result_reject=1, since tile 0 is empty.
- Match all 8 pairs → match_count=8, game_done=1, req_ready stays 0; a further req_valid gets no response.
- Assert reset during HOLD → next cycle: state IDLE, reveal_active=0, no result_valid, match_count=0, req_ready=1.
